// File: rtl/regfile_pkg.sv
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared constants and arbiter state encoding for the register
//                file write-port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int RF_AW    = 4;
    localparam int RF_DW    = 16;
    localparam int RF_DEPTH = 16;

    // Arbiter FSM encoding
    typedef logic [0:0] arb_state_t;
    localparam arb_state_t ST_ARB    = 1'b0;
    localparam arb_state_t ST_LOCKED = 1'b1;

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/regfile_wr_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker. Searches the request
//                vector starting at the pointer and wrapping around, and
//                returns a one-hot grant plus the granted index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // First requester at or after the pointer (with wrap) wins
    always_comb begin
        logic [IW:0]   w_sum;
        logic [IW-1:0] w_pos;
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        w_sum   = '0;
        w_pos   = '0;
        for (int i = 0; i < N; i++) begin
            w_sum = {1'b0, i_ptr} + (IW+1)'(i);
            if (w_sum >= (IW+1)'(N)) begin
                w_sum = w_sum - (IW+1)'(N);
            end
            w_pos = w_sum[IW-1:0];
            if (!o_any && i_req[w_pos]) begin
                o_any          = 1'b1;
                o_idx          = w_pos;
                o_grant[w_pos] = 1'b1;
            end
        end
    end

endmodule : rr_pick

`default_nettype wire

// File: rtl/regfile_wr_arbiter.sv
// ============================================================================
//  Module      : regfile_wr_arbiter
//  Description : Round-robin arbiter sharing the single register-file write
//                port among NREQ requesters, with optional burst lock and a
//                registered write-port drive.
//                Build option: REGFILE_WR_ZERO_PROTECT_EN - beats addressed
//                to register 0 are handshaken but never written.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int AW   = RF_AW,
    parameter int DW   = RF_DW
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    hold_i,
    input  logic [NREQ-1:0]         req_valid_i,
    input  logic [NREQ-1:0]         req_lock_i,
    input  logic [NREQ*AW-1:0]      req_addr_i,
    input  logic [NREQ*DW-1:0]      req_data_i,
    output logic [NREQ-1:0]         req_ready_o,
    output logic                    wr_en_o,
    output logic [AW-1:0]           wr_addr_o,
    output logic [DW-1:0]           wr_data_o,
    output logic [$clog2(NREQ)-1:0] owner_o,
    output logic                    locked_o
);

    localparam int IW = $clog2(NREQ);

    arb_state_t      r_state;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_owner;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr;
    logic [DW-1:0]   r_wr_data;

    logic [NREQ-1:0] w_owner_oh;
    logic [NREQ-1:0] w_pick_req;
    logic [NREQ-1:0] w_grant;
    logic [IW-1:0]   w_pick_idx;
    logic            w_pick_any;
    logic            w_block;
    logic            w_accept;
    logic [AW-1:0]   w_sel_addr;
    logic [DW-1:0]   w_sel_data;
    logic            w_sel_lock;
    logic [IW-1:0]   w_next_ptr;
    logic            w_wr_en_next;

    // While locked only the owner is eligible; otherwise everyone competes
    always_comb begin
        w_owner_oh = {{(NREQ-1){1'b0}}, 1'b1} << r_owner;
        w_pick_req = (r_state == ST_LOCKED) ? (req_valid_i & w_owner_oh) : req_valid_i;
    end

    rr_pick #(
        .N  (NREQ),
        .IW (IW)
    ) u_rr_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_pick_idx),
        .o_any   (w_pick_any)
    );

    // Handshake gating and selection of the granted beat
    always_comb begin
        w_block     = rst_i | hold_i;
        req_ready_o = w_block ? '0 : w_grant;
        w_accept    = w_pick_any & ~w_block;
        w_sel_addr  = req_addr_i[w_pick_idx*AW +: AW];
        w_sel_data  = req_data_i[w_pick_idx*DW +: DW];
        w_sel_lock  = req_lock_i[w_pick_idx];
        w_next_ptr  = (w_pick_idx == IW'(NREQ-1)) ? '0 : w_pick_idx + 1'b1;
`ifdef REGFILE_WR_ZERO_PROTECT_EN
        // Register 0 is read-only zero: accept the beat but suppress the write
        w_wr_en_next = w_accept & (w_sel_addr != '0);
`else
        w_wr_en_next = w_accept;
`endif
    end

    // FSM, pointer, owner and registered write-port drive
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_ARB;
            r_ptr     <= '0;
            r_owner   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en <= w_wr_en_next;
            if (w_accept) begin
                r_ptr     <= w_next_ptr;
                r_owner   <= w_pick_idx;
                r_wr_addr <= w_sel_addr;
                r_wr_data <= w_sel_data;
                r_state   <= w_sel_lock ? ST_LOCKED : ST_ARB;
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign owner_o   = r_owner;
    assign locked_o  = (r_state == ST_LOCKED);

endmodule : regfile_wr_arbiter

`default_nettype wire

// File: tb/tb_regfile_wr_arbiter.sv
// ============================================================================
//  Module      : tb_regfile_wr_arbiter
//  Description : Scoreboard bench for regfile_wr_arbiter with a 16x16
//                register-file model attached to the write port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_wr_arbiter;

`ifdef REGFILE_WR_ZERO_PROTECT_EN
    localparam bit ZP = 1'b1;
`else
    localparam bit ZP = 1'b0;
`endif

    typedef struct packed {
        logic [3:0]  a;
        logic [15:0] d;
        logic [1:0]  o;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [3:0]  valid;
    logic [3:0]  lock;
    logic [15:0] req_addr;
    logic [63:0] req_data;
    logic [3:0]  ready;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  owner;
    logic        locked;

    logic [3:0]  t_addr [4];
    logic [15:0] t_data [4];
    logic [15:0] rf [16];
    logic        rf_clr;

    exp_t        q [$];
    int          n_checks;
    int          n_fail;

    regfile_wr_arbiter #(.NREQ(4), .AW(4), .DW(16)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .hold_i      (hold),
        .req_valid_i (valid),
        .req_lock_i  (lock),
        .req_addr_i  (req_addr),
        .req_data_i  (req_data),
        .req_ready_o (ready),
        .wr_en_o     (wr_en),
        .wr_addr_o   (wr_addr),
        .wr_data_o   (wr_data),
        .owner_o     (owner),
        .locked_o    (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int k = 0; k < 4; k++) begin
            req_addr[k*4 +: 4]   = t_addr[k];
            req_data[k*16 +: 16] = t_data[k];
        end
    end

    // Register-file model fed by the write port
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int k = 0; k < 16; k++) rf[k] <= 16'h0000;
        end else if (wr_en === 1'b1) begin
            rf[wr_addr] <= wr_data;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every write presented on the port must match the next expected beat
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %h data %h, expected no write", wr_addr, wr_data);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d || owner !== e.o) begin
                    n_fail++;
                    $display("FAIL write_beat: got a=%h d=%h own=%0d expected a=%h d=%h own=%0d",
                             wr_addr, wr_data, owner, e.a, e.d, e.o);
                end
            end
        end
    end

    // Inputs already set; check the grant, queue the expected write, advance one edge
    task automatic beat(input string nm, input logic [3:0] exp_rdy);
        int   idx;
        exp_t e;
        #1;
        chk(nm, {28'd0, ready}, {28'd0, exp_rdy});
        if (exp_rdy != 4'b0000) begin
            idx = 0;
            for (int k = 0; k < 4; k++) if (exp_rdy[k]) idx = k;
            if (!(ZP && t_addr[idx] == 4'd0)) begin
                e.a = t_addr[idx];
                e.d = t_data[idx];
                e.o = 2'(idx);
                q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rf_clr   = 1'b1;
        rst      = 1'b1;
        hold     = 1'b0;
        valid    = 4'b1111;
        lock     = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            t_addr[k] = 4'(k);
            t_data[k] = 16'hA000 | 16'(k);
        end

        // Reset with all requesters valid
        beat("rst_ready0", 4'b0000);
        beat("rst_ready1", 4'b0000);
        chk("rst_wr_en",  {31'd0, wr_en},  32'd0);
        chk("rst_owner",  {30'd0, owner},  32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_addr",   {28'd0, wr_addr}, 32'd0);
        rst    = 1'b0;
        rf_clr = 1'b0;

        // Round-robin fairness
        beat("rr0", 4'b0001);
        beat("rr1", 4'b0010);
        beat("rr2", 4'b0100);
        beat("rr3", 4'b1000);
        beat("rr4", 4'b0001);
        valid = 4'b0000;
        beat("rr_idle0", 4'b0000);
        beat("rr_idle1", 4'b0000);
        chk("rr_r1", {16'd0, rf[1]}, 32'h0000A001);

        // Lock burst by req1 while req0/req2 wait
        t_addr[0] = 4'd4;  t_data[0] = 16'h0400;
        t_addr[2] = 4'd8;  t_data[2] = 16'h0802;
        valid = 4'b0111; lock = 4'b0010;
        t_addr[1] = 4'd5;  t_data[1] = 16'h0001;
        beat("lk_b1", 4'b0010);
        chk("lk_locked1", {31'd0, locked}, 32'd1);
        t_addr[1] = 4'd6;  t_data[1] = 16'h0002;
        beat("lk_b2", 4'b0010);
        valid = 4'b0101;
        beat("lk_owner_idle", 4'b0000);
        chk("lk_still_locked", {31'd0, locked}, 32'd1);
        valid = 4'b0111; lock = 4'b0000;
        t_addr[1] = 4'd7;  t_data[1] = 16'h0003;
        beat("lk_b3", 4'b0010);
        chk("lk_unlocked", {31'd0, locked}, 32'd0);
        valid = 4'b0101;
        beat("lk_next_req2", 4'b0100);
        valid = 4'b0001;
        beat("lk_then_req0", 4'b0001);

        // Hold blocks grants; the write port idles afterwards
        hold = 1'b1; valid = 4'b0011;
        beat("hold_nogrant", 4'b0000);
        chk("hold_wr_en", {31'd0, wr_en}, 32'd0);
        hold = 1'b0;
        beat("hold_release", 4'b0010);
        valid = 4'b0101; lock = 4'b0100;
        beat("lk2_grant", 4'b0100);
        chk("lk2_locked", {31'd0, locked}, 32'd1);
        hold = 1'b1;
        beat("lk2_hold", 4'b0000);
        chk("lk2_hold_locked", {31'd0, locked}, 32'd1);
        chk("lk2_hold_wr_en",  {31'd0, wr_en},  32'd0);
        hold = 1'b0; rst = 1'b1;
        beat("rst_mid_lock", 4'b0000);
        chk("rst_mid_locked", {31'd0, locked}, 32'd0);
        chk("rst_mid_owner",  {30'd0, owner},  32'd0);
        chk("rst_mid_wr_en",  {31'd0, wr_en},  32'd0);
        rst = 1'b0; lock = 4'b0000;
        beat("post_rst_req0", 4'b0001);

        // Same-address collision with pointer at 3
        valid = 4'b0010; t_addr[1] = 4'd10; t_data[1] = 16'h0A0A;
        beat("col_pre1", 4'b0010);
        valid = 4'b0100; t_addr[2] = 4'd11; t_data[2] = 16'h0B0B;
        beat("col_pre2", 4'b0100);
        valid = 4'b1001;
        t_addr[0] = 4'd9; t_data[0] = 16'h1111;
        t_addr[3] = 4'd9; t_data[3] = 16'h3333;
        beat("col_req3", 4'b1000);
        valid = 4'b0001;
        beat("col_req0", 4'b0001);
        valid = 4'b0000;
        beat("col_idle0", 4'b0000);
        beat("col_idle1", 4'b0000);
        chk("col_r9", {16'd0, rf[9]}, 32'h00001111);

        // Address-0 write
        valid = 4'b0010; t_addr[1] = 4'd0; t_data[1] = 16'hFFFF;
        beat("zp_ready", 4'b0010);
        valid = 4'b0000;
        beat("zp_idle0", 4'b0000);
        beat("zp_idle1", 4'b0000);
        chk("zp_r0", {16'd0, rf[0]}, ZP ? 32'h00000000 : 32'h0000FFFF);

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_regfile_wr_arbiter

`default_nettype wire
